// File: rtl/jesd204b_link_pkg.sv
// rtl/jesd204b_link_pkg.sv - shared constants and ILAS octet helper for the JESD204B TX link
package jesd204b_link_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_4 = 8'h9C;

  localparam logic [1:0] ST_CGS  = 2'd0;
  localparam logic [1:0] ST_ILAS = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam int ILAS_MULTIFRAMES = 4;
  localparam int ILAS_CFG_OCTETS  = 14;

  // Returns {k, octet} for ILAS octet index i of multiframe mf.
  function automatic logic [8:0] ilas_octet(
    input logic [7:0]                     i,
    input logic [1:0]                     mf,
    input logic [7:0]                     last_idx,
    input logic [ILAS_CFG_OCTETS*8-1:0]   cfg
  );
    logic [8:0] r;
    if (i == 8'd0)
      r = {1'b1, K28_0};
    else if (i == last_idx)
      r = {1'b1, K28_3};
    else if (mf == 2'd1 && i == 8'd1)
      r = {1'b1, K28_4};
    else if (mf == 2'd1 && i >= 8'd2 && i <= 8'd15)
      r = {1'b0, cfg[(int'(i) - 2) * 8 +: 8]};
    else
      r = {1'b0, i};
    return r;
  endfunction

endpackage

// File: rtl/jesd204b_lmfc_counter.sv
// rtl/jesd204b_lmfc_counter.sv - free-running LMFC octet counter, shareable across lanes
module jesd204b_lmfc_counter #(
  parameter int F = 2,
  parameter int K = 16
) (
  input  logic       clock,
  input  logic       reset,
  output logic [7:0] cnt,
  output logic       last
);

  assign last = (cnt == 8'(F * K - 1));

  // Count 0..F*K-1 and wrap; only reset clears it, never the link state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      cnt <= 8'd0;
    else
      cnt <= last ? 8'd0 : cnt + 8'd1;
  end

endmodule

// File: rtl/jesd204b_tx_link_ctrl.sv
// rtl/jesd204b_tx_link_ctrl.sv - JESD204B TX lane sequencer CGS/ILAS/DATA; ILAS compiled only with JESD_ILAS_EN
module jesd204b_tx_link_ctrl
  import jesd204b_link_pkg::*;
#(
  parameter int F            = 2,
  parameter int K            = 16,
  parameter int SYNC_LOW_MIN = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         sync_n,
  input  logic [7:0]   data_in,
  input  logic [111:0] ilas_cfg,
  output logic [7:0]   tx_octet,
  output logic         tx_k,
  output logic         data_en,
  output logic         link_up,
  output logic         lmfc_pulse,
  output logic [1:0]   state
);

  localparam int RW = $clog2(SYNC_LOW_MIN + 1);

  logic [7:0]    lmfc_cnt;
  logic          lmfc_last;
  logic [7:0]    lmfc_nxt;
  logic [RW-1:0] low_run;
  logic [RW-1:0] low_run_nxt;
  logic          resync;
  logic [1:0]    state_nxt;
  logic [7:0]    octet_nxt;
  logic          k_nxt;

`ifdef JESD_ILAS_EN
  logic [1:0] mf_cnt;
  logic [1:0] mf_nxt;
`else
  logic unused_ilas_cfg;
  assign unused_ilas_cfg = ^ilas_cfg;
`endif

  jesd204b_lmfc_counter #(.F(F), .K(K)) u_lmfc (
    .clock (clock),
    .reset (reset),
    .cnt   (lmfc_cnt),
    .last  (lmfc_last)
  );

  // Outputs are registered from next-cycle values so they line up with lmfc_cnt.
  assign lmfc_nxt = lmfc_last ? 8'd0 : lmfc_cnt + 8'd1;

  // Count consecutive low sync_n samples outside CGS; a full run forces resync.
  always_comb begin
    resync      = 1'b0;
    low_run_nxt = low_run;
    if (state == ST_CGS || sync_n) begin
      low_run_nxt = '0;
    end else if (low_run == RW'(SYNC_LOW_MIN - 1)) begin
      resync      = 1'b1;
      low_run_nxt = '0;
    end else begin
      low_run_nxt = low_run + 1'b1;
    end
  end

  // Link state transitions; resync overrides everything, including ILAS end.
  always_comb begin
    state_nxt = state;
`ifdef JESD_ILAS_EN
    mf_nxt = mf_cnt;
`endif
    case (state)
      ST_CGS: begin
        if (sync_n && lmfc_last) begin
`ifdef JESD_ILAS_EN
          state_nxt = ST_ILAS;
          mf_nxt    = 2'd0;
`else
          state_nxt = ST_DATA;
`endif
        end
      end
`ifdef JESD_ILAS_EN
      ST_ILAS: begin
        if (lmfc_last) begin
          mf_nxt = mf_cnt + 2'd1;
          if (mf_cnt == 2'(ILAS_MULTIFRAMES - 1))
            state_nxt = ST_DATA;
        end
      end
`endif
      default: ;
    endcase
    if (resync)
      state_nxt = ST_CGS;
  end

  // Select the octet the encoder sees after the coming edge.
  always_comb begin
    octet_nxt = K28_5;
    k_nxt     = 1'b1;
    case (state_nxt)
      ST_DATA: begin
        octet_nxt = data_in;
        k_nxt     = 1'b0;
      end
`ifdef JESD_ILAS_EN
      ST_ILAS: {k_nxt, octet_nxt} = ilas_octet(lmfc_nxt, mf_nxt, 8'(F * K - 1), ilas_cfg);
`endif
      default: ;
    endcase
  end

  // State, counters and registered outputs; reset drops the lane back to CGS at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_CGS;
      low_run    <= '0;
      tx_octet   <= K28_5;
      tx_k       <= 1'b1;
      data_en    <= 1'b0;
      link_up    <= 1'b0;
      lmfc_pulse <= 1'b1;
`ifdef JESD_ILAS_EN
      mf_cnt     <= 2'd0;
`endif
    end else begin
      state      <= state_nxt;
      low_run    <= low_run_nxt;
      tx_octet   <= octet_nxt;
      tx_k       <= k_nxt;
      data_en    <= (state_nxt == ST_DATA);
      link_up    <= (state_nxt == ST_DATA);
      lmfc_pulse <= (lmfc_nxt == 8'd0);
`ifdef JESD_ILAS_EN
      mf_cnt     <= mf_nxt;
`endif
    end
  end

endmodule
